// File: rtl/sirv_qspi_arbiter_n_if.sv
// Shared-link bundle for the N-way QSPI arbiter: N inner front-end channels plus
// the single outer link to the QSPI engine. The arbiter uses the slave view.
interface sirv_qspi_arbiter_n_if #(
  parameter int N = 2
);
  logic [N-1:0]   io_inner_tx_valid;
  logic [8*N-1:0] io_inner_tx_bits;
  logic [N-1:0]   io_inner_tx_ready;
  logic [N-1:0]   io_inner_rx_valid;
  logic [8*N-1:0] io_inner_rx_bits;
  logic [8*N-1:0] io_inner_cnt;
  logic [2*N-1:0] io_inner_fmt_proto;
  logic [N-1:0]   io_inner_fmt_endian;
  logic [N-1:0]   io_inner_fmt_iodir;
  logic [N-1:0]   io_inner_cs_set;
  logic [N-1:0]   io_inner_cs_clear;
  logic [N-1:0]   io_inner_cs_hold;
  logic [N-1:0]   io_inner_lock;
  logic [N-1:0]   io_inner_active;

  logic           io_outer_tx_valid;
  logic [7:0]     io_outer_tx_bits;
  logic           io_outer_tx_ready;
  logic           io_outer_rx_valid;
  logic [7:0]     io_outer_rx_bits;
  logic [7:0]     io_outer_cnt;
  logic [1:0]     io_outer_fmt_proto;
  logic           io_outer_fmt_endian;
  logic           io_outer_fmt_iodir;
  logic           io_outer_cs_set;
  logic           io_outer_cs_clear;
  logic           io_outer_cs_hold;
  logic           io_outer_active;

  modport slave (
    input  io_inner_tx_valid, io_inner_tx_bits, io_inner_cnt, io_inner_fmt_proto,
           io_inner_fmt_endian, io_inner_fmt_iodir, io_inner_cs_set, io_inner_cs_clear,
           io_inner_cs_hold, io_inner_lock,
           io_outer_tx_ready, io_outer_rx_valid, io_outer_rx_bits, io_outer_active,
    output io_inner_tx_ready, io_inner_rx_valid, io_inner_rx_bits, io_inner_active,
           io_outer_tx_valid, io_outer_tx_bits, io_outer_cnt, io_outer_fmt_proto,
           io_outer_fmt_endian, io_outer_fmt_iodir, io_outer_cs_set, io_outer_cs_clear,
           io_outer_cs_hold
  );

  modport master (
    output io_inner_tx_valid, io_inner_tx_bits, io_inner_cnt, io_inner_fmt_proto,
           io_inner_fmt_endian, io_inner_fmt_iodir, io_inner_cs_set, io_inner_cs_clear,
           io_inner_cs_hold, io_inner_lock,
           io_outer_tx_ready, io_outer_rx_valid, io_outer_rx_bits, io_outer_active,
    input  io_inner_tx_ready, io_inner_rx_valid, io_inner_rx_bits, io_inner_active,
           io_outer_tx_valid, io_outer_tx_bits, io_outer_cnt, io_outer_fmt_proto,
           io_outer_fmt_endian, io_outer_fmt_iodir, io_outer_cs_set, io_outer_cs_clear,
           io_outer_cs_hold
  );
endinterface

// File: rtl/sirv_qspi_arbiter_n.sv
// N-way QSPI link arbiter: software-select or round-robin ownership, with a
// CS-released drain phase on every ownership change.
module sirv_qspi_arbiter_n #(
  parameter int N    = 2,
  parameter int SELW = $clog2(N)
) (
  input  logic                   clock,
  input  logic                   rst_n,
  sirv_qspi_arbiter_n_if.slave   io,
  input  logic                   io_auto,
  input  logic [SELW-1:0]        io_sel,
  output logic [SELW-1:0]        io_owner,
  output logic                   io_switching
);

  typedef enum logic {OWN = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] owner_q, owner_d;
  logic [SELW-1:0] pend_q, pend_d;
  logic [SELW-1:0] target;
  logic            target_ok;
  logic            switch_req;

  // Candidate owner: software select, or the first channel after the owner
  // (wrapping) with TX data pending, only once the owner itself has gone quiet.
  always_comb begin : p_target
    int idx;
    idx       = 0;
    target    = '0;
    target_ok = 1'b0;
    if (!io_auto) begin
      if (int'(io_sel) < N) begin
        target    = io_sel;
        target_ok = 1'b1;
      end
    end else if (!io.io_inner_tx_valid[owner_q]) begin
      for (int k = 1; k < N; k++) begin
        idx = (int'(owner_q) + k) % N;
        if (!target_ok && io.io_inner_tx_valid[idx]) begin
          target    = idx[SELW-1:0];
          target_ok = 1'b1;
        end
      end
    end
  end

  assign switch_req = (state_q == OWN) && target_ok && (target != owner_q) &&
                      !io.io_inner_lock[owner_q];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    pend_d  = pend_q;
    case (state_q)
      OWN: begin
        if (switch_req) begin
          pend_d  = target;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!io.io_outer_active) begin
          owner_d = pend_q;
          state_d = OWN;
        end
      end
      default: state_d = OWN;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OWN;
      owner_q <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pend_q  <= pend_d;
    end
  end

  // Outer link follows the owner; during DRAIN TX is blocked and CS forced clear,
  // while RX/active keep routing to the old owner so in-flight data lands.
  always_comb begin : p_mux
    int ow;
    ow = int'(owner_q);
    io.io_outer_tx_valid   = (state_q == OWN) && io.io_inner_tx_valid[ow];
    io.io_outer_tx_bits    = io.io_inner_tx_bits[8*ow +: 8];
    io.io_outer_cnt        = io.io_inner_cnt[8*ow +: 8];
    io.io_outer_fmt_proto  = io.io_inner_fmt_proto[2*ow +: 2];
    io.io_outer_fmt_endian = io.io_inner_fmt_endian[ow];
    io.io_outer_fmt_iodir  = io.io_inner_fmt_iodir[ow];
    io.io_outer_cs_set     = io.io_inner_cs_set[ow];
    io.io_outer_cs_hold    = io.io_inner_cs_hold[ow];
    io.io_outer_cs_clear   = (state_q == DRAIN) ? 1'b1 : io.io_inner_cs_clear[ow];

    io.io_inner_tx_ready   = '0;
    io.io_inner_rx_valid   = '0;
    io.io_inner_active     = '0;
    if (state_q == OWN) io.io_inner_tx_ready[ow] = io.io_outer_tx_ready;
    io.io_inner_rx_valid[ow] = io.io_outer_rx_valid;
    io.io_inner_active[ow]   = io.io_outer_active;
  end

  assign io.io_inner_rx_bits = {N{io.io_outer_rx_bits}};
  assign io_owner            = owner_q;
  assign io_switching        = (state_q == DRAIN);

endmodule

// File: tb/tb_sirv_qspi_arbiter_n.sv
// Scoreboard bench: one stimulus stream drives an N=4 and an N=3 arbiter; a
// behavioural model queues expected outputs, a negedge monitor pops and compares.
module tb_sirv_qspi_arbiter_n;

  typedef struct packed {
    logic        rst_n;
    logic [3:0]  tx_valid;
    logic [31:0] tx_bits;
    logic [31:0] cnt;
    logic [7:0]  proto;
    logic [3:0]  endian, iodir, cs_set, cs_clear, cs_hold, lock;
    logic        otx_ready, orx_valid, oactive;
    logic [7:0]  orx_bits;
    logic        auto;
    logic [1:0]  sel;
  } stim_t;

  typedef struct packed {
    logic [1:0]  owner;
    logic        sw;
    logic        txv;
    logic [7:0]  txb;
    logic [7:0]  cnt;
    logic [1:0]  proto;
    logic        endian, iodir, cs_set, cs_clear, cs_hold;
    logic [3:0]  tx_ready, rx_valid, active;
    logic [31:0] rx_bits;
  } exp_t;

  logic  clock;
  stim_t nx, cur;
  exp_t  q4[$], q3[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    m_own[2], m_pend[2];
  bit    m_drain[2];

  logic [1:0] owner4, owner3;
  logic       sw4, sw3;

  sirv_qspi_arbiter_n_if #(.N(4)) if4 ();
  sirv_qspi_arbiter_n_if #(.N(3)) if3 ();

  assign if4.io_inner_tx_valid   = cur.tx_valid;
  assign if4.io_inner_tx_bits    = cur.tx_bits;
  assign if4.io_inner_cnt        = cur.cnt;
  assign if4.io_inner_fmt_proto  = cur.proto;
  assign if4.io_inner_fmt_endian = cur.endian;
  assign if4.io_inner_fmt_iodir  = cur.iodir;
  assign if4.io_inner_cs_set     = cur.cs_set;
  assign if4.io_inner_cs_clear   = cur.cs_clear;
  assign if4.io_inner_cs_hold    = cur.cs_hold;
  assign if4.io_inner_lock       = cur.lock;
  assign if4.io_outer_tx_ready   = cur.otx_ready;
  assign if4.io_outer_rx_valid   = cur.orx_valid;
  assign if4.io_outer_rx_bits    = cur.orx_bits;
  assign if4.io_outer_active     = cur.oactive;

  assign if3.io_inner_tx_valid   = cur.tx_valid[2:0];
  assign if3.io_inner_tx_bits    = cur.tx_bits[23:0];
  assign if3.io_inner_cnt        = cur.cnt[23:0];
  assign if3.io_inner_fmt_proto  = cur.proto[5:0];
  assign if3.io_inner_fmt_endian = cur.endian[2:0];
  assign if3.io_inner_fmt_iodir  = cur.iodir[2:0];
  assign if3.io_inner_cs_set     = cur.cs_set[2:0];
  assign if3.io_inner_cs_clear   = cur.cs_clear[2:0];
  assign if3.io_inner_cs_hold    = cur.cs_hold[2:0];
  assign if3.io_inner_lock       = cur.lock[2:0];
  assign if3.io_outer_tx_ready   = cur.otx_ready;
  assign if3.io_outer_rx_valid   = cur.orx_valid;
  assign if3.io_outer_rx_bits    = cur.orx_bits;
  assign if3.io_outer_active     = cur.oactive;

  sirv_qspi_arbiter_n #(.N(4)) u4 (
    .clock(clock), .rst_n(cur.rst_n), .io(if4), .io_auto(cur.auto), .io_sel(cur.sel),
    .io_owner(owner4), .io_switching(sw4)
  );

  sirv_qspi_arbiter_n #(.N(3)) u3 (
    .clock(clock), .rst_n(cur.rst_n), .io(if3), .io_auto(cur.auto), .io_sel(cur.sel),
    .io_owner(owner3), .io_switching(sw3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Expected outputs for an n-channel arbiter given its owner and phase.
  function automatic exp_t model_out(int n, int own, bit drain);
    exp_t e;
    e          = '0;
    e.owner    = own[1:0];
    e.sw       = drain;
    e.txv      = !drain && cur.tx_valid[own];
    e.txb      = cur.tx_bits[8*own +: 8];
    e.cnt      = cur.cnt[8*own +: 8];
    e.proto    = cur.proto[2*own +: 2];
    e.endian   = cur.endian[own];
    e.iodir    = cur.iodir[own];
    e.cs_set   = cur.cs_set[own];
    e.cs_hold  = cur.cs_hold[own];
    e.cs_clear = drain ? 1'b1 : cur.cs_clear[own];
    if (!drain) e.tx_ready[own] = cur.otx_ready;
    e.rx_valid[own] = cur.orx_valid;
    e.active[own]   = cur.oactive;
    for (int i = 0; i < n; i++) e.rx_bits[8*i +: 8] = cur.orx_bits;
    return e;
  endfunction

  task automatic model_cycle(int d);
    int n, tgt;
    n = (d == 0) ? 4 : 3;
    if (!cur.rst_n) begin
      m_own[d] = 0; m_pend[d] = 0; m_drain[d] = 1'b0;
    end
    if (d == 0) q4.push_back(model_out(n, m_own[d], m_drain[d]));
    else        q3.push_back(model_out(n, m_own[d], m_drain[d]));
    if (!cur.rst_n) return;
    if (m_drain[d]) begin
      if (!cur.oactive) begin
        m_own[d]   = m_pend[d];
        m_drain[d] = 1'b0;
      end
    end else begin
      tgt = -1;
      if (!cur.auto) begin
        if (int'(cur.sel) < n) tgt = int'(cur.sel);
      end else if (!cur.tx_valid[m_own[d]]) begin
        for (int k = n - 1; k >= 1; k--)
          if (cur.tx_valid[(m_own[d] + k) % n]) tgt = (m_own[d] + k) % n;
      end
      if (tgt >= 0 && tgt != m_own[d] && !cur.lock[m_own[d]]) begin
        m_pend[d]  = tgt;
        m_drain[d] = 1'b1;
      end
    end
  endtask

  task automatic step(int cycles);
    repeat (cycles) begin
      @(posedge clock);
      #1;
      cur = nx;
      model_cycle(0);
      model_cycle(1);
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare(string tag, exp_t a, exp_t e);
    chk({tag, ".owner"},    32'(a.owner),    32'(e.owner));
    chk({tag, ".switching"},32'(a.sw),       32'(e.sw));
    chk({tag, ".tx_valid"}, 32'(a.txv),      32'(e.txv));
    chk({tag, ".tx_bits"},  32'(a.txb),      32'(e.txb));
    chk({tag, ".cnt"},      32'(a.cnt),      32'(e.cnt));
    chk({tag, ".proto"},    32'(a.proto),    32'(e.proto));
    chk({tag, ".fmt"},      {30'd0, a.endian, a.iodir}, {30'd0, e.endian, e.iodir});
    chk({tag, ".cs_set"},   32'(a.cs_set),   32'(e.cs_set));
    chk({tag, ".cs_clear"}, 32'(a.cs_clear), 32'(e.cs_clear));
    chk({tag, ".cs_hold"},  32'(a.cs_hold),  32'(e.cs_hold));
    chk({tag, ".tx_ready"}, 32'(a.tx_ready), 32'(e.tx_ready));
    chk({tag, ".rx_valid"}, 32'(a.rx_valid), 32'(e.rx_valid));
    chk({tag, ".active"},   32'(a.active),   32'(e.active));
    chk({tag, ".rx_bits"},  a.rx_bits,       e.rx_bits);
  endtask

  // Monitor: sample away from the active edge and retire one entry per DUT.
  initial begin
    exp_t a;
    forever begin
      @(negedge clock);
      if (q4.size() > 0) begin
        a = '{owner: owner4, sw: sw4, txv: if4.io_outer_tx_valid, txb: if4.io_outer_tx_bits,
              cnt: if4.io_outer_cnt, proto: if4.io_outer_fmt_proto,
              endian: if4.io_outer_fmt_endian, iodir: if4.io_outer_fmt_iodir,
              cs_set: if4.io_outer_cs_set, cs_clear: if4.io_outer_cs_clear,
              cs_hold: if4.io_outer_cs_hold, tx_ready: if4.io_inner_tx_ready,
              rx_valid: if4.io_inner_rx_valid, active: if4.io_inner_active,
              rx_bits: if4.io_inner_rx_bits};
        compare("n4", a, q4.pop_front());
      end
      if (q3.size() > 0) begin
        a = '{owner: owner3, sw: sw3, txv: if3.io_outer_tx_valid, txb: if3.io_outer_tx_bits,
              cnt: if3.io_outer_cnt, proto: if3.io_outer_fmt_proto,
              endian: if3.io_outer_fmt_endian, iodir: if3.io_outer_fmt_iodir,
              cs_set: if3.io_outer_cs_set, cs_clear: if3.io_outer_cs_clear,
              cs_hold: if3.io_outer_cs_hold, tx_ready: {1'b0, if3.io_inner_tx_ready},
              rx_valid: {1'b0, if3.io_inner_rx_valid}, active: {1'b0, if3.io_inner_active},
              rx_bits: {8'h00, if3.io_inner_rx_bits}};
        compare("n3", a, q3.pop_front());
      end
    end
  end

  initial begin
    nx          = '0;
    nx.rst_n    = 1'b0;
    nx.tx_bits  = 32'h77_3C_5A_A5;
    nx.cnt      = 32'h40_30_20_10;
    nx.proto    = 8'b10_01_00_10;
    nx.cs_hold  = 4'b1010;
    nx.cs_clear = 4'b0110;
    nx.otx_ready = 1'b1;
    nx.orx_bits = 8'hC3;
    cur         = nx;
    m_own   = '{0, 0};
    m_pend  = '{0, 0};
    m_drain = '{1'b0, 1'b0};

    // Reset state, then a static switch 0 -> 2 with an idle link.
    step(3);
    nx.rst_n = 1'b1; step(2);
    nx.sel = 2'd2; step(4);

    // Back to 0, then lock blocks a switch; released lock drains with link busy.
    nx.sel = 2'd0; step(3);
    nx.lock = 4'b0001; nx.sel = 2'd1; step(5);
    nx.lock = 4'b0000; nx.oactive = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nx.orx_valid = ~nx.orx_valid;
      step(1);
      nx.lock = 4'b0001;
    end
    nx.oactive = 1'b0; nx.lock = 4'b0000; step(3);

    // Select 3: valid for N=4, ignored by N=3; then round-robin wrap from 3.
    nx.sel = 2'd3; nx.cs_clear = 4'b0101; step(2);
    nx.cs_clear = 4'b1010; step(2);
    nx.auto = 1'b1; nx.tx_valid = 4'b0101; step(3);
    nx.tx_valid = 4'b0100; step(3);

    // Reset asserted mid-drain discards the pending owner.
    nx.auto = 1'b0; nx.tx_valid = 4'b0000; nx.sel = 2'd1; nx.oactive = 1'b1; step(2);
    nx.rst_n = 1'b0; step(1);
    nx.rst_n = 1'b1; nx.sel = 2'd0; nx.oactive = 1'b0; step(3);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) nx.auto = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) nx.sel = 2'($urandom);
      nx.tx_valid  = 4'($urandom & $urandom);
      nx.tx_bits   = $urandom;
      nx.cnt       = $urandom;
      nx.proto     = 8'($urandom);
      nx.endian    = 4'($urandom);
      nx.iodir     = 4'($urandom);
      nx.cs_set    = 4'($urandom);
      nx.cs_clear  = 4'($urandom);
      nx.cs_hold   = 4'($urandom);
      nx.lock      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      nx.otx_ready = 1'($urandom);
      nx.orx_valid = 1'($urandom);
      nx.orx_bits  = 8'($urandom);
      nx.oactive   = ($urandom_range(0, 2) == 0);
      nx.rst_n     = ($urandom_range(0, 150) != 0);
      step(1);
    end

    @(negedge clock);
    #1;
    chk("scoreboard_empty4", 32'(q4.size()), 32'd0);
    chk("scoreboard_empty3", 32'(q3.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
